run_sequencer: RTL and testbench

Run controller that sits directly upstream of the processor top level. It accepts a start request, holds the core in reset for a fixed number of cycles, then releases it and counts execution cycles until the core's `done` flag asserts or a timeout expires. It holds the result (cycle count, timeout flag) until acknowledged. It is the single point through which a test harness or host launches the core.

---
 rtl/run_sequencer_pkg.sv | 9 +
 rtl/seq_counter.sv | 18 +
 rtl/run_sequencer.sv | 87 ++++++++
 tb/tb_run_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/run_sequencer_pkg.sv
// run_seq_pkg: sequencer state encoding and default parameter values
package run_seq_pkg;
    typedef enum logic [2:0] {IDLE, HOLD, RUN, DONE, TIMEOUT} run_state_t;
    localparam int RST_CYCLES_DEF     = 4;
    localparam int IGNORE_CYCLES_DEF  = 2;
    localparam int CNT_W_DEF          = 16;
    localparam int TIMEOUT_CYCLES_DEF = 50000;
    localparam int HOLD_W             = 4;
endpackage

// File: rtl/seq_counter.sv
// seq_counter: up-counter with synchronous clear/enable and async active-low reset
module seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: holds the core in reset, runs it, and latches cycle count on done or timeout
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int RST_CYCLES     = RST_CYCLES_DEF,
    parameter int IGNORE_CYCLES  = IGNORE_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ack,
    input  logic             core_done,
    output logic             core_reset,
    output logic             busy,
    output logic             finished,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);
    run_state_t state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic core_reset_q, core_reset_d, busy_q, busy_d;
    logic finished_q, finished_d, timeout_q, timeout_d;
    logic done_acc, hold_end, last_cycle;

    // core done is combinational from the PC, so it is untrustworthy for the first few cycles
    assign done_acc   = state_q == RUN && core_done && cycle_count >= CNT_W'(IGNORE_CYCLES);
    assign hold_end   = hold_cnt == HOLD_W'(RST_CYCLES - 1);
    assign last_cycle = cycle_count == CNT_W'(TIMEOUT_CYCLES - 1);

    seq_counter #(.W(HOLD_W)) u_hold (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (state_q == IDLE),
        .en_i  (state_q == HOLD),
        .cnt_o (hold_cnt)
    );

    seq_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (state_q == HOLD && hold_end),
        .en_i  (state_q == RUN && !done_acc),
        .cnt_o (cycle_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          state_d = start ? HOLD : IDLE;
            HOLD:          state_d = hold_end ? RUN : HOLD;
            RUN:           state_d = done_acc ? DONE : last_cycle ? TIMEOUT : RUN;
            DONE, TIMEOUT: state_d = ack ? IDLE : state_q;
            default:       state_d = IDLE;
        endcase
    end

    // outputs are registered from the next state so they change on the same edge as the state
    always_comb begin
        core_reset_d = state_d != RUN;
        busy_d       = state_d == HOLD || state_d == RUN;
        finished_d   = state_d == DONE;
        timeout_d    = state_d == TIMEOUT;
    end

    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign finished   = finished_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboard bench for run_sequencer with RST=4, IGNORE=2, TIMEOUT=100
module tb_run_sequencer;
    localparam int RST = 4;
    localparam int IGN = 2;
    localparam int TO  = 100;
    localparam int W   = 16;

    typedef struct {
        int fin;
        int to;
        int cnt;
        int lat;
    } exp_t;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, ack = 1'b0, core_done = 1'b0;
    logic core_reset, busy, finished, timeout;
    logic [W-1:0] cycle_count;
    exp_t exp_q[$];
    exp_t last;
    int n_chk = 0;
    int n_pass = 0;

    run_sequencer #(
        .RST_CYCLES     (RST),
        .IGNORE_CYCLES  (IGN),
        .CNT_W          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ack         (ack),
        .core_done   (core_done),
        .core_reset  (core_reset),
        .busy        (busy),
        .finished    (finished),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    // done_at < 0 means the core never raises done
    function automatic exp_t model(input int done_at);
        exp_t r;
        int acc;
        acc = done_at > IGN ? done_at : IGN;
        if (done_at < 0 || acc >= TO) begin
            r.fin = 0; r.to = 1; r.cnt = TO; r.lat = RST + TO;
        end else begin
            r.fin = 1; r.to = 0; r.cnt = acc; r.lat = RST + acc + 1;
        end
        return r;
    endfunction

    task automatic run_case(input int done_at);
        int e;
        bit seen;
        exp_q.push_back(model(done_at));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        e = 0;
        seen = 1'b0;
        while (e < 300 && !seen) begin
            if (e == RST - 1) chk("core_reset_in_hold", core_reset, 1);
            if (e == RST)     chk("core_reset_in_run", core_reset, 0);
            start = (e == RST + 3);
            if (done_at >= 0 && e >= RST + done_at) core_done = 1'b1;
            if (finished || timeout) seen = 1'b1;
            else begin
                @(negedge clk);
                e++;
            end
        end
        start = 1'b0;
        core_done = 1'b0;
        chk("result_seen", seen, 1);
        last = exp_q.pop_front();
        chk("finished", finished, last.fin);
        chk("timeout", timeout, last.to);
        chk("cycle_count", cycle_count, last.cnt);
        chk("latency", e, last.lat);
        chk("busy_at_end", busy, 0);
        chk("core_reset_at_end", core_reset, 1);
        @(negedge clk);
        chk("result_held", finished | timeout, 1);
        chk("count_held", cycle_count, last.cnt);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_finished", finished, 0);
        chk("ack_timeout", timeout, 0);
        chk("ack_busy", busy, 0);
        chk("ack_count_kept", cycle_count, last.cnt);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_count", cycle_count, 0);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        run_case(7);
        do_ack();

        run_case(0);
        ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        start = 1'b0;
        chk("ackstart_idle", busy, 0);
        chk("ackstart_cleared", finished, 0);
        @(negedge clk);
        chk("ackstart_no_launch", busy, 0);

        run_case(-1);
        do_ack();

        run_case(99);
        do_ack();

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RST + 5) @(negedge clk);
        chk("mid_run_count", cycle_count, 5);
        chk("mid_run_core_reset", core_reset, 0);
        reset = 1'b0;
        #1;
        chk("abort_core_reset", core_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_finished", finished, 0);
        chk("abort_timeout", timeout, 0);
        chk("abort_count", cycle_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_abort_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
